// File: rtl/ni_pkg.sv
// ----------------------------------------------------------------------------
// ni_pkg
// Shared definitions for the network-interface flit packetizer/depacketizer:
// flit field widths, flit type codes, receive FSM state encoding and a helper
// that sizes the per-packet word address from the maximum body length.
// ----------------------------------------------------------------------------
package ni_pkg;

    localparam int FLIT_W    = 18;
    localparam int PAYLOAD_W = 16;
    localparam int ADDR_W    = 8;

    // Flit type field, flit[17:16]
    localparam logic [1:0] FLIT_IDLE = 2'b00;
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_BODY = 2'b10;
    localparam logic [1:0] FLIT_TAIL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BODY  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DROP  = 2'd3
    } rx_state_e;

    // Width of a 0-based index into a packet of up to max_body words.
    // Never returns 0 so a degenerate MAX_BODY=1 still yields a legal vector.
    function automatic int word_addr_w(input int max_body);
        return (max_body > 1) ? $clog2(max_body) : 1;
    endfunction

endpackage

// File: rtl/ni_flit_depacketizer_if.sv
// ----------------------------------------------------------------------------
// ni_flit_depacketizer_if
// Bundles the two streaming channels of the receive NI:
//   flit channel : flit_in[17:0], flit_valid  -> ; <- flit_ready
//   word channel : data_out[15:0], word_addr, data_valid -> ; <- data_ready
// modport slave  : the depacketizer (consumes flits, produces words)
// modport master : the environment (router side + SRAM write side)
// ----------------------------------------------------------------------------
interface ni_flit_depacketizer_if #(
    parameter int MAX_BODY = 16
);
    localparam int AW = ni_pkg::word_addr_w(MAX_BODY);

    logic [ni_pkg::FLIT_W-1:0]    flit_in;
    logic                         flit_valid;
    logic                         flit_ready;
    logic [ni_pkg::PAYLOAD_W-1:0] data_out;
    logic [AW-1:0]                word_addr;
    logic                         data_valid;
    logic                         data_ready;

    modport slave (
        input  flit_in, flit_valid, data_ready,
        output flit_ready, data_out, word_addr, data_valid
    );

    modport master (
        output flit_in, flit_valid, data_ready,
        input  flit_ready, data_out, word_addr, data_valid
    );

endinterface

// File: rtl/ni_out_slot.sv
// ----------------------------------------------------------------------------
// ni_out_slot
// Single-entry valid/ready holding register.
//   clk, reset     : clock, asynchronous active-low reset
//   load/load_data : write a new entry (caller only loads when free=1)
//   ready          : downstream accepts the entry when valid && ready
//   valid/data     : held entry, stable until accepted
//   free           : slot can take a load this cycle (empty or draining)
// A load and a drain in the same cycle replace the entry and keep valid high.
// ----------------------------------------------------------------------------
module ni_out_slot #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         free
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign free  = !valid_q || ready;

endmodule

// File: rtl/ni_flit_depacketizer.sv
// ----------------------------------------------------------------------------
// ni_flit_depacketizer
// Receive-side NI: strips the head flit, filters on destination address,
// delivers body payloads as indexed 16-bit words and verifies the XOR
// checksum carried in the tail.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : flit channel in, word channel out (ni_flit_depacketizer_if)
//   src_addr   : source of the current/last accepted head
//   packet_end : one-cycle pulse once the last word of a good packet is taken
//   pkt_len    : body word count, valid with packet_end
//   csum_err   : tail checksum mismatch, valid with packet_end
//   proto_err  : one-cycle pulse on an out-of-place flit or body overflow
// ----------------------------------------------------------------------------
module ni_flit_depacketizer
    import ni_pkg::*;
#(
    parameter logic [ADDR_W-1:0] NODE_ADDR = 8'h00,
    parameter int                MAX_BODY  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    ni_flit_depacketizer_if.slave         bus,
    output logic [ADDR_W-1:0]             src_addr,
    output logic                          packet_end,
    output logic [word_addr_w(MAX_BODY):0] pkt_len,
    output logic                          csum_err,
    output logic                          proto_err
);

    localparam int AW = word_addr_w(MAX_BODY);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BODY);

    rx_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [PAYLOAD_W-1:0]   csum_q, csum_d;
    logic                   csum_err_r_q, csum_err_r_d;
    logic [ADDR_W-1:0]      src_addr_q, src_addr_d;
    logic                   packet_end_q, packet_end_d;
    logic [CW-1:0]          pkt_len_q, pkt_len_d;
    logic                   csum_err_q, csum_err_d;
    logic                   proto_err_q, proto_err_d;

    logic [1:0]             flit_type;
    logic [PAYLOAD_W-1:0]   payload;
    logic                   ready_c;
    logic                   flit_ready_c;
    logic                   flit_acc;
    logic                   head_seen;
    logic                   slot_load;
    logic                   slot_valid;
    logic                   slot_free;
    logic [PAYLOAD_W+AW-1:0] slot_in;
    logic [PAYLOAD_W+AW-1:0] slot_out;

    assign flit_type = bus.flit_in[FLIT_W-1 -: 2];
    assign payload   = bus.flit_in[PAYLOAD_W-1:0];

    ni_out_slot #(
        .W(PAYLOAD_W + AW)
    ) u_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (slot_load),
        .load_data (slot_in),
        .ready     (bus.data_ready),
        .valid     (slot_valid),
        .data      (slot_out),
        .free      (slot_free)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        csum_d       = csum_q;
        csum_err_r_d = csum_err_r_q;
        src_addr_d   = src_addr_q;
        packet_end_d = 1'b0;
        pkt_len_d    = pkt_len_q;
        csum_err_d   = csum_err_q;
        proto_err_d  = 1'b0;
        slot_load    = 1'b0;
        slot_in      = {cnt_q[AW-1:0], payload};
        head_seen    = 1'b0;

        case (state_q)
            ST_IDLE:  ready_c = 1'b1;
            ST_BODY:  ready_c = slot_free;
            ST_DROP:  ready_c = 1'b1;
            default:  ready_c = 1'b0;
        endcase
        // Hold off the router while reset is asserted.
        flit_ready_c = ready_c && reset;
        flit_acc     = bus.flit_valid && flit_ready_c;

        case (state_q)
            ST_IDLE: begin
                if (flit_acc) begin
                    if (flit_type == FLIT_HEAD) begin
                        head_seen = 1'b1;
                    end else if (flit_type != FLIT_IDLE) begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            ST_BODY: begin
                if (flit_acc) begin
                    case (flit_type)
                        FLIT_HEAD: begin
                            // Abandon the open packet; the head is re-evaluated below.
                            proto_err_d = 1'b1;
                            head_seen   = 1'b1;
                        end
                        FLIT_BODY: begin
                            if (cnt_q < CNT_MAX) begin
                                slot_load = 1'b1;
                                cnt_d     = cnt_q + CW'(1);
                                csum_d    = csum_q ^ payload;
                            end else begin
                                proto_err_d = 1'b1;
                                state_d     = ST_DROP;
                            end
                        end
                        FLIT_TAIL: begin
                            csum_err_r_d = (csum_q != payload);
                            state_d      = ST_FLUSH;
                        end
                        default: ;
                    endcase
                end
            end
            ST_FLUSH: begin
                // Two-phase: raise packet_end once the slot empties, then
                // return to IDLE while packet_end is visible, so the next
                // head is taken the cycle after the pulse.
                if (packet_end_q) begin
                    state_d = ST_IDLE;
                end else if (slot_free) begin
                    packet_end_d = 1'b1;
                    pkt_len_d    = cnt_q;
                    csum_err_d   = csum_err_r_q;
                end
            end
            ST_DROP: begin
                if (flit_acc) begin
                    if (flit_type == FLIT_HEAD) begin
                        proto_err_d = 1'b1;
                        head_seen   = 1'b1;
                    end else if (flit_type == FLIT_TAIL) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (head_seen) begin
            src_addr_d = payload[ADDR_W-1:0];
            if (payload[PAYLOAD_W-1:ADDR_W] == NODE_ADDR) begin
                state_d = ST_BODY;
                cnt_d   = '0;
                csum_d  = '0;
            end else begin
                state_d = ST_DROP;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            csum_q       <= '0;
            csum_err_r_q <= 1'b0;
            src_addr_q   <= '0;
            packet_end_q <= 1'b0;
            pkt_len_q    <= '0;
            csum_err_q   <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            csum_q       <= csum_d;
            csum_err_r_q <= csum_err_r_d;
            src_addr_q   <= src_addr_d;
            packet_end_q <= packet_end_d;
            pkt_len_q    <= pkt_len_d;
            csum_err_q   <= csum_err_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign bus.flit_ready = flit_ready_c;
    assign bus.data_valid = slot_valid;
    assign bus.data_out   = slot_out[PAYLOAD_W-1:0];
    assign bus.word_addr  = slot_out[PAYLOAD_W +: AW];
    assign src_addr       = src_addr_q;
    assign packet_end     = packet_end_q;
    assign pkt_len        = pkt_len_q;
    assign csum_err       = csum_err_q;
    assign proto_err      = proto_err_q;

endmodule

// File: doc/ni_flit_depacketizer.md
Name: ni_flit_depacketizer

Overview:
Receive-side network-interface block. It takes the 18-bit typed flit stream (head/body/tail) arriving from the router port and strips the head flit. It checks the destination address against this node and delivers body payloads as 16-bit words, each with a local word address, toward the SRAM write port. Tail checksum is verified, and a one-cycle packet_end marks completion after the last word has been handed off.

Parameters:
NODE_ADDR, 8'h00, this node's address; head dest_addr must match or the packet is dropped
MAX_BODY, 16, maximum body flits per packet; word_addr width = clog2(MAX_BODY)

Ports:
clk  in  1  main clock, rising edge
reset  in  1  asynchronous, active-low reset
flit_in  in  18  [17:16] type (00 idle/invalid, 01 head, 10 body, 11 tail), [15:0] payload
flit_valid  in  1  flit_in valid
flit_ready  out  1  flit accepted when flit_valid && flit_ready
data_out  out  16  body payload word
word_addr  out  clog2(MAX_BODY)  index of data_out within the packet (0-based)
data_valid  out  1  data_out/word_addr valid
data_ready  in  1  sink accepts the word when data_valid && data_ready
src_addr  out  8  src of the current/last accepted packet (head payload [7:0])
packet_end  out  1  one-cycle pulse after the last word of a good-address packet is consumed
pkt_len  out  clog2(MAX_BODY)+1  body word count; valid while packet_end=1
csum_err  out  1  valid with packet_end: tail payload != XOR of all body payloads
proto_err  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; flit_ready, data_valid, packet_end, csum_err, proto_err=0; data_out, word_addr, src_addr, pkt_len=0; checksum and word counter=0.
- Output slot: single holding register. data_valid stays 1 until data_ready. Accepted body at cycle N -> data_valid at N+1.
- FSM states: IDLE, BODY, FLUSH, DROP.
- IDLE:
  - flit_ready=1.
  - Head accepted: src_addr<=payload[7:0]. If payload[15:8]==NODE_ADDR -> BODY with csum=0, cnt=0. Otherwise -> DROP.
  - Body or tail accepted: discarded, proto_err pulse, stay in IDLE.
  - Type 00 with valid: ignored, no error.
- BODY:
  - flit_ready = !data_valid || data_ready.
  - Body accepted with cnt<MAX_BODY: load slot, word_addr<=cnt, cnt++, csum^=payload.
  - Body accepted with cnt==MAX_BODY: proto_err, -> DROP.
  - Tail accepted: csum_err_r<=(csum!=payload), -> FLUSH.
  - Head accepted: proto_err, current packet abandoned with no packet_end, restart as IDLE-head processing in the same cycle.
- FLUSH:
  - flit_ready=0.
  - When data_valid==0 (or is being cleared this cycle): packet_end=1 for exactly one cycle, pkt_len=cnt, csum_err=csum_err_r, -> IDLE.
  - A zero-body packet (head then tail) gives packet_end with pkt_len=0 and csum_err=(tail!=0).
- DROP:
  - flit_ready=1.
  - All flits are discarded, no data_valid.
  - Tail -> IDLE with no packet_end.
  - Head -> proto_err, treated as a new head.
- Simultaneous events: slot load and slot drain in the same cycle keeps data_valid=1 and carries the new word. Back-to-back packets: next head is accepted the cycle after packet_end.
- Reset mid-packet: everything is discarded immediately; the partially delivered word is lost.
- Widths: cnt saturates at MAX_BODY and never wraps. XOR checksum is 16-bit.

Decomposition:
- Shared package ni_pkg: flit type constants FLIT_IDLE/HEAD/BODY/TAIL (2'b00..2'b11), FLIT_W=18, PAYLOAD_W=16, ADDR_W=8, and the FSM state enum. The packetizer shares the same package.
- One natural sub-module: ni_out_slot, the single-entry valid/ready holding register, reusable on the transmit side.

Test Plan:
- Good packet: head 0x0005 (dest 00, src 05), body 0x1111, 0x2222, tail 0x3333, data_ready=1 -> words 0x1111@0 then 0x2222@1. packet_end one cycle after the last word handoff, pkt_len=2, csum_err=0, src_addr=05.
- Same packet with tail 0x3334 -> packet_end, csum_err=1, both words still delivered.
- Backpressure: data_ready held 0 for 5 cycles after the first body -> flit_ready=0, data_out holds 0x1111 stable, no flit lost. On release, words are in order and packet_end only after the second word is consumed.
- Wrong dest: head 0x0705 -> body/tail consumed (flit_ready=1), data_valid never 1, no packet_end, proto_err=0.
- Protocol errors:
  - Body in IDLE -> proto_err pulse.
  - Head mid-BODY -> proto_err, first packet has no packet_end, second packet completes normally.
  - MAX_BODY+1 bodies -> proto_err, DROP until tail.
- Async reset asserted mid-BODY (not clock-aligned) -> outputs 0 immediately. After release, a new good packet completes with word_addr starting at 0.
